// File: rtl/pic_pc_sequencer_if.sv
// Handshake bundle between pic_pc_sequencer (master) and the decoder/fetch side (slave).
// Carries the end-of-cycle control requests and the phase, PC and status outputs.
interface pic_pc_sequencer_if #(
    parameter int unsigned PC_WIDTH = 13,
    parameter int unsigned PHASES   = 4
);
    localparam int unsigned QW = (PHASES > 2) ? $clog2(PHASES) : 1;

    logic                do_branch;
    logic                do_call;
    logic                do_ret;
    logic                do_skip;
    logic [PC_WIDTH-1:0] target;
    logic                int_req;
    logic [QW-1:0]       q_phase;
    logic                cycle_end;
    logic                instr_rd_en;
    logic [PC_WIDTH-1:0] pc_out;
    logic                exec_nop;
    logic                int_ack;
    logic                stack_ovf;
    logic                stack_unf;

    modport master (
        input  do_branch, do_call, do_ret, do_skip, target, int_req,
        output q_phase, cycle_end, instr_rd_en, pc_out, exec_nop, int_ack,
               stack_ovf, stack_unf
    );

    modport slave (
        output do_branch, do_call, do_ret, do_skip, target, int_req,
        input  q_phase, cycle_end, instr_rd_en, pc_out, exec_nop, int_ack,
               stack_ovf, stack_unf
    );
endinterface

// File: rtl/pic_pc_sequencer.sv
// Q-phase counter, program counter and circular return stack for the midrange core.
// Define PIC_STACK_ERR_EN to enable the sticky stack_ovf / stack_unf flags.
module pic_pc_sequencer #(
    parameter int unsigned PC_WIDTH     = 13,
    parameter int unsigned PHASES       = 4,
    parameter int unsigned STACK_DEPTH  = 8,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned INT_VECTOR   = 4
) (
    input logic                  clk,
    input logic                  rst,
    pic_pc_sequencer_if.master   bus
);
    localparam int unsigned QW  = (PHASES > 2) ? $clog2(PHASES) : 1;
    localparam int unsigned SPW = $clog2(STACK_DEPTH);

    logic [QW-1:0]       phase_q, phase_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                nop_q, nop_d;
    logic                ack_q, ack_d;
    logic [SPW-1:0]      sp_q, sp_d;
    logic                push, pop;
    logic                cyc_end;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] stack_top;

    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];

    assign cyc_end   = (phase_q == QW'(PHASES - 1));
    assign pc_inc    = pc_q + PC_WIDTH'(1);
    assign stack_top = stack_mem[sp_q - SPW'(1)];

    always_comb begin
        phase_d = cyc_end ? '0 : phase_q + QW'(1);
        pc_d    = pc_q;
        nop_d   = nop_q;
        ack_d   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        if (cyc_end) begin
            if (nop_q) begin
                // Flushed slot: requests from the discarded instruction are ignored.
                pc_d  = pc_inc;
                nop_d = 1'b0;
            end else if (bus.do_ret) begin
                pop   = 1'b1;
                pc_d  = stack_top;
                nop_d = 1'b1;
            end else if (bus.do_call) begin
                push  = 1'b1;
                pc_d  = bus.target;
                nop_d = 1'b1;
            end else if (bus.do_branch) begin
                pc_d  = bus.target;
                nop_d = 1'b1;
            end else if (bus.do_skip) begin
                pc_d  = pc_inc;
                nop_d = 1'b1;
            end else if (bus.int_req) begin
                push  = 1'b1;
                pc_d  = PC_WIDTH'(INT_VECTOR);
                nop_d = 1'b1;
                ack_d = 1'b1;
            end else begin
                pc_d  = pc_inc;
            end
        end
    end

    always_comb begin
        sp_d = sp_q;
        if (push) begin
            sp_d = sp_q + SPW'(1);
        end else if (pop) begin
            sp_d = sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            pc_q    <= PC_WIDTH'(RESET_VECTOR);
            nop_q   <= 1'b1;
            ack_q   <= 1'b0;
            sp_q    <= '0;
        end else begin
            phase_q <= phase_d;
            pc_q    <= pc_d;
            nop_q   <= nop_d;
            ack_q   <= ack_d;
            sp_q    <= sp_d;
        end
    end

    // Contents are deliberately left unreset; the pushed value is the prefetch address.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[sp_q] <= pc_q;
        end
    end

`ifdef PIC_STACK_ERR_EN
    localparam int unsigned CW = SPW + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          cnt_full, cnt_empty;

    assign cnt_full  = (cnt_q == CW'(STACK_DEPTH));
    assign cnt_empty = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (push) begin
            if (cnt_full) ovf_d = 1'b1;
            else          cnt_d = cnt_q + CW'(1);
        end else if (pop) begin
            if (cnt_empty) unf_d = 1'b1;
            else           cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.stack_ovf = ovf_q;
    assign bus.stack_unf = unf_q;
`else
    assign bus.stack_ovf = 1'b0;
    assign bus.stack_unf = 1'b0;
`endif

    assign bus.q_phase     = phase_q;
    assign bus.cycle_end   = cyc_end;
    assign bus.instr_rd_en = (phase_q == '0);
    assign bus.pc_out      = pc_q;
    assign bus.exec_nop    = nop_q;
    assign bus.int_ack     = ack_q;
endmodule

// File: tb/tb_pic_pc_sequencer.sv
// Scoreboard bench for pic_pc_sequencer: the driver queues the expected state at each
// instruction-cycle start, and a monitor pops and compares when the next cycle begins.
module tb_pic_pc_sequencer;
    localparam int unsigned PW = 13;
    localparam int unsigned PH = 4;
`ifdef PIC_STACK_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    typedef struct packed {
        logic [PW-1:0] pc;
        logic          nop;
        logic          ack;
        logic          ovf;
        logic          unf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb [$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   exp_ph;
    logic cur_ack = 1'b0;
    logic [PW-1:0] p [1:9];
    logic [PW-1:0] t [1:9];
    logic [PW-1:0] v;

    pic_pc_sequencer_if #(.PC_WIDTH(PW), .PHASES(PH)) bus ();

    pic_pc_sequencer #(
        .PC_WIDTH(PW), .PHASES(PH), .STACK_DEPTH(8), .RESET_VECTOR(0), .INT_VECTOR(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference phase counter.
    always @(posedge clk or posedge rst) begin
        if (rst) exp_ph <= 0;
        else     exp_ph <= (exp_ph == PH - 1) ? 0 : exp_ph + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic br, input logic cl, input logic rt, input logic sk,
                       input logic ir, input logic [PW-1:0] tgt, input logic [PW-1:0] epc,
                       input logic enop, input logic eack, input logic eovf,
                       input logic eunf);
        exp_t e;
        e.pc  = epc;
        e.nop = enop;
        e.ack = eack;
        e.ovf = eovf & ERR;
        e.unf = eunf & ERR;
        sb.push_back(e);
        bus.do_branch = br;
        bus.do_call   = cl;
        bus.do_ret    = rt;
        bus.do_skip   = sk;
        bus.int_req   = ir;
        bus.target    = tgt;
        repeat (PH) @(negedge clk);
    endtask

    task automatic chk_reset_vals();
        chk("rst_q_phase", 32'(bus.q_phase), 0);
        chk("rst_pc_out", 32'(bus.pc_out), 0);
        chk("rst_exec_nop", 32'(bus.exec_nop), 1);
        chk("rst_int_ack", 32'(bus.int_ack), 0);
        chk("rst_instr_rd_en", 32'(bus.instr_rd_en), 1);
        chk("rst_cycle_end", 32'(bus.cycle_end), 0);
        chk("rst_stack_ovf", 32'(bus.stack_ovf), 0);
        chk("rst_stack_unf", 32'(bus.stack_unf), 0);
    endtask

    // Monitor: checks phase decodes every clock and pops the scoreboard at each cycle start.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                chk("q_phase", 32'(bus.q_phase), 32'(exp_ph));
                chk("instr_rd_en", 32'(bus.instr_rd_en), 32'(exp_ph == 0));
                chk("cycle_end", 32'(bus.cycle_end), 32'(exp_ph == PH - 1));
                if (exp_ph == 0) begin
                    cur_ack = 1'b0;
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        cur_ack = e.ack;
                        chk("pc_out", 32'(bus.pc_out), 32'(e.pc));
                        chk("exec_nop", 32'(bus.exec_nop), 32'(e.nop));
                        chk("stack_ovf", 32'(bus.stack_ovf), 32'(e.ovf));
                        chk("stack_unf", 32'(bus.stack_unf), 32'(e.unf));
                    end
                end
                chk("int_ack", 32'(bus.int_ack), 32'((exp_ph == 0) && cur_ack));
            end
        end
    end

    initial begin
        bus.do_branch = 1'b0;
        bus.do_call   = 1'b0;
        bus.do_ret    = 1'b0;
        bus.do_skip   = 1'b0;
        bus.int_req   = 1'b0;
        bus.target    = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;

        //  br   cl   rt   sk   ir   target   exp_pc   nop  ack  ovf  unf
        cyc(1'b0,1'b0,1'b0,1'b0,1'b0,13'h000, 13'h000, 1'b1,1'b0,1'b0,1'b0);
        cyc(1'b0,1'b0,1'b0,1'b0,1'b0,13'h000, 13'h001, 1'b0,1'b0,1'b0,1'b0);
        cyc(1'b0,1'b0,1'b0,1'b0,1'b0,13'h000, 13'h002, 1'b0,1'b0,1'b0,1'b0);
        cyc(1'b0,1'b0,1'b0,1'b0,1'b0,13'h000, 13'h003, 1'b0,1'b0,1'b0,1'b0);
        cyc(1'b0,1'b0,1'b0,1'b0,1'b0,13'h000, 13'h004, 1'b0,1'b0,1'b0,1'b0);
        cyc(1'b1,1'b0,1'b0,1'b0,1'b0,13'h123, 13'h005, 1'b0,1'b0,1'b0,1'b0);
        cyc(1'b1,1'b0,1'b0,1'b0,1'b0,13'h050, 13'h123, 1'b1,1'b0,1'b0,1'b0);
        cyc(1'b1,1'b0,1'b0,1'b0,1'b0,13'h010, 13'h124, 1'b0,1'b0,1'b0,1'b0);
        cyc(1'b0,1'b0,1'b0,1'b0,1'b0,13'h000, 13'h010, 1'b1,1'b0,1'b0,1'b0);
        cyc(1'b0,1'b1,1'b0,1'b0,1'b0,13'h200, 13'h011, 1'b0,1'b0,1'b0,1'b0);
        cyc(1'b0,1'b0,1'b0,1'b0,1'b0,13'h000, 13'h200, 1'b1,1'b0,1'b0,1'b0);
        cyc(1'b0,1'b0,1'b0,1'b0,1'b0,13'h000, 13'h201, 1'b0,1'b0,1'b0,1'b0);
        cyc(1'b0,1'b0,1'b1,1'b0,1'b0,13'h000, 13'h202, 1'b0,1'b0,1'b0,1'b0);
        cyc(1'b0,1'b0,1'b0,1'b0,1'b0,13'h000, 13'h011, 1'b1,1'b0,1'b0,1'b0);
        cyc(1'b0,1'b0,1'b0,1'b1,1'b1,13'h000, 13'h012, 1'b0,1'b0,1'b0,1'b0);
        cyc(1'b0,1'b0,1'b0,1'b0,1'b1,13'h000, 13'h013, 1'b1,1'b0,1'b0,1'b0);
        cyc(1'b0,1'b0,1'b0,1'b0,1'b1,13'h000, 13'h014, 1'b0,1'b0,1'b0,1'b0);
        cyc(1'b0,1'b0,1'b0,1'b0,1'b0,13'h000, 13'h004, 1'b1,1'b1,1'b0,1'b0);
        cyc(1'b0,1'b0,1'b1,1'b0,1'b0,13'h000, 13'h005, 1'b0,1'b0,1'b0,1'b0);
        cyc(1'b0,1'b0,1'b0,1'b0,1'b0,13'h000, 13'h014, 1'b1,1'b0,1'b0,1'b0);

        // Nine nested calls into an eight-entry stack: call k at p[k] jumps to t[k].
        p[1] = 13'h015;
        for (int k = 1; k <= 9; k++) begin
            t[k] = 13'(32'h100 + 32'h10 * k);
            if (k < 9) p[k+1] = t[k] + 13'd1;
        end
        for (int k = 1; k <= 9; k++) begin
            cyc(1'b0,1'b1,1'b0,1'b0,1'b0,t[k], p[k], 1'b0,1'b0,1'b0,1'b0);
            cyc(1'b0,1'b0,1'b0,1'b0,1'b0,13'h0, t[k], 1'b1,1'b0,(k == 9),1'b0);
        end
        // Returns 1 and 9 both land on p[9]; returns 2..8 unwind p[8]..p[2].
        v = t[9] + 13'd1;
        for (int j = 1; j <= 9; j++) begin
            cyc(1'b0,1'b0,1'b1,1'b0,1'b0,13'h0, v, 1'b0,1'b0,1'b1,1'b0);
            v = (j == 1 || j == 9) ? p[9] : p[10-j];
            cyc(1'b0,1'b0,1'b0,1'b0,1'b0,13'h0, v, 1'b1,1'b0,1'b1,(j == 9));
            v = v + 13'd1;
        end

        // Branch cycle interrupted by reset at q_phase 2.
        sb.push_back('{pc: v, nop: 1'b0, ack: 1'b0, ovf: ERR, unf: ERR});
        bus.do_branch = 1'b1;
        bus.target    = 13'h0aa;
        repeat (2) @(posedge clk);
        #2;
        chk("pre_rst_q_phase", 32'(bus.q_phase), 2);
        rst = 1'b1;
        bus.do_branch = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        // sp is back at 0, so the first pop reads slot 7 (p[8]); count 0 flags underflow.
        cyc(1'b0,1'b0,1'b0,1'b0,1'b0,13'h000, 13'h000, 1'b1,1'b0,1'b0,1'b0);
        cyc(1'b0,1'b0,1'b1,1'b0,1'b0,13'h000, 13'h001, 1'b0,1'b0,1'b0,1'b0);
        cyc(1'b0,1'b0,1'b0,1'b0,1'b0,13'h000, p[8],    1'b1,1'b0,1'b0,1'b1);
        cyc(1'b0,1'b0,1'b0,1'b0,1'b0,13'h000, p[8] + 13'd1, 1'b0,1'b0,1'b0,1'b1);
        sb.push_back('{pc: p[8] + 13'd2, nop: 1'b0, ack: 1'b0, ovf: 1'b0, unf: ERR});
        @(negedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
